// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : multicycle program-counter controller (BOOT/FETCH/EXEC/HALTED)
// Optional taken-branch counter: define PC_SEQUENCER_BRANCH_COUNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'h0001
) (
   input  logic        clk_pi,
   input  logic        rst_n_pi,
   input  logic        stall_pi,
   input  logic        imem_ack_pi,
   input  logic        exec_done_pi,
   input  logic        is_branch_taken_pi,
   input  logic [15:0] branch_offset_pi,
   input  logic        jump_pi,
   input  logic [15:0] jump_target_pi,
   input  logic        halt_pi,
   output logic        imem_req_po,
   output logic [15:0] imem_addr_po,
   output logic [15:0] pc_po,
   output logic        instr_valid_po,
   output logic        redirect_po,
   output logic        halted_po,
   output logic [15:0] branch_taken_count_po
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic        instr_valid, instr_valid_nxt;
   logic        redirect, redirect_nxt;
   logic        fetch_req;

   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         redirect    <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr_valid <= instr_valid_nxt;
         redirect    <= redirect_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      instr_valid_nxt = 1'b0;
      redirect_nxt    = 1'b0;
      fetch_req       = 1'b0;
      case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            fetch_req = !stall_pi;
            if (fetch_req && imem_ack_pi) begin
               state_nxt       = EXEC;
               instr_valid_nxt = 1'b1;
            end
         end
         EXEC: begin
            // Priority halt > jump > taken branch > sequential
            if (exec_done_pi) begin
               if (halt_pi) begin
                  state_nxt = HALTED;
               end else begin
                  state_nxt = FETCH;
                  if (jump_pi) begin
                     pc_nxt       = jump_target_pi;
                     redirect_nxt = 1'b1;
                  end else if (is_branch_taken_pi) begin
                     pc_nxt       = pc + PC_STEP + branch_offset_pi;
                     redirect_nxt = 1'b1;
                  end else begin
                     pc_nxt = pc + PC_STEP;
                  end
               end
            end
         end
         HALTED: state_nxt = HALTED;
         default: state_nxt = BOOT;
      endcase
   end

   assign imem_req_po    = fetch_req;
   assign imem_addr_po   = pc;
   assign pc_po          = pc;
   assign instr_valid_po = instr_valid;
   assign redirect_po    = redirect;
   assign halted_po      = (state == HALTED);

`ifdef PC_SEQUENCER_BRANCH_COUNT_EN
   logic [15:0] branch_count;
   logic        branch_hit;

   assign branch_hit = (state == EXEC) && exec_done_pi && !halt_pi
                       && !jump_pi && is_branch_taken_pi;

   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         branch_count <= 16'h0000;
      end else if (branch_hit && (branch_count != 16'hFFFF)) begin
         branch_count <= branch_count + 16'h0001;
      end
   end

   assign branch_taken_count_po = branch_count;
`else
   assign branch_taken_count_po = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : randomized directed bench for pc_sequencer with PC model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, ack = 1'b0, done = 1'b0;
   logic        br = 1'b0, jump = 1'b0, halt = 1'b0;
   logic [15:0] off = 16'h0000, tgt = 16'h0000;
   logic        req, valid, redirect, halted;
   logic [15:0] addr, pc, cnt;

   pc_sequencer dut (
      .clk_pi                (clk),
      .rst_n_pi              (rst_n),
      .stall_pi              (stall),
      .imem_ack_pi           (ack),
      .exec_done_pi          (done),
      .is_branch_taken_pi    (br),
      .branch_offset_pi      (off),
      .jump_pi               (jump),
      .jump_target_pi        (tgt),
      .halt_pi               (halt),
      .imem_req_po           (req),
      .imem_addr_po          (addr),
      .pc_po                 (pc),
      .instr_valid_po        (valid),
      .redirect_po           (redirect),
      .halted_po             (halted),
      .branch_taken_count_po (cnt)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Reference model: architectural PC, pending redirect flag, branch count
   logic [15:0] m_pc = 16'h0000;
   logic        m_redir = 1'b0;
   logic [15:0] m_cnt = 16'h0000;

   localparam int K_SEQ = 0, K_BR = 1, K_JMP = 2, K_JMPBR = 3, K_HALT = 4;

   function automatic logic [15:0] exp_cnt();
`ifdef PC_SEQUENCER_BRANCH_COUNT_EN
      return m_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      stall = 1'b0; ack = 1'b0; done = 1'b0;
      br = 1'b0; jump = 1'b0; halt = 1'b0;
      off = 16'h0000; tgt = 16'h0000;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pc"}, pc, 16'h0000);
      chk({tag, "_req"}, {15'd0, req}, 16'd0);
      chk({tag, "_valid"}, {15'd0, valid}, 16'd0);
      chk({tag, "_redir"}, {15'd0, redirect}, 16'd0);
      chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
      chk({tag, "_cnt"}, cnt, 16'h0000);
   endtask

   // Reset asserted at a negedge, released one cycle later; checks the BOOT cycle.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b1;
      m_pc = 16'h0000; m_redir = 1'b0; m_cnt = 16'h0000;
      #1;
      chk("boot_req", {15'd0, req}, 16'd0);
      chk("boot_pc", pc, 16'h0000);
   endtask

   // One full instruction from the first FETCH cycle through the done cycle.
   task automatic run_instr(input int stalls, input int ack_dly, input int done_dly,
                            input int kind, input logic [15:0] o, input logic [15:0] t);
      int cyc = 0;
      for (int i = 0; i < stalls; i++) begin
         @(negedge clk);
         clear_inputs();
         stall = 1'b1; ack = 1'b1;
         #1;
         chk("stall_req", {15'd0, req}, 16'd0);
         chk("stall_valid", {15'd0, valid}, 16'd0);
         chk("stall_redir", {15'd0, redirect}, (cyc == 0) ? {15'd0, m_redir} : 16'd0);
         if (cyc == 0) chk("cnt", cnt, exp_cnt());
         cyc++;
      end
      for (int i = 0; i <= ack_dly; i++) begin
         @(negedge clk);
         clear_inputs();
         ack = (i == ack_dly);
         #1;
         chk("fetch_req", {15'd0, req}, 16'd1);
         chk("fetch_addr", addr, m_pc);
         chk("fetch_valid", {15'd0, valid}, 16'd0);
         chk("fetch_redir", {15'd0, redirect}, (cyc == 0) ? {15'd0, m_redir} : 16'd0);
         if (cyc == 0) chk("cnt", cnt, exp_cnt());
         cyc++;
      end
      for (int i = 0; i <= done_dly; i++) begin
         @(negedge clk);
         stall = 1'($urandom); ack = 1'($urandom);
         if (i == done_dly) begin
            done = 1'b1;
            halt = (kind == K_HALT);
            jump = (kind == K_JMP) || (kind == K_JMPBR);
            br   = (kind == K_BR) || (kind == K_JMPBR);
            off = o; tgt = t;
         end else begin
            done = 1'b0;
            halt = 1'($urandom); jump = 1'($urandom); br = 1'($urandom);
            off = 16'($urandom); tgt = 16'($urandom);
         end
         #1;
         chk("exec_req", {15'd0, req}, 16'd0);
         chk("exec_valid", {15'd0, valid}, (i == 0) ? 16'd1 : 16'd0);
         chk("exec_redir", {15'd0, redirect}, 16'd0);
         chk("exec_pc", pc, m_pc);
      end
      case (kind)
         K_HALT: m_redir = 1'b0;
         K_JMP, K_JMPBR: begin m_pc = t; m_redir = 1'b1; end
         K_BR: begin
            m_pc = m_pc + 16'd1 + o;
            m_redir = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         default: begin m_pc = m_pc + 16'd1; m_redir = 1'b0; end
      endcase
   endtask

   task automatic check_halted(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         stall = 1'($urandom); ack = 1'b1; done = 1'b1;
         jump = 1'b1; br = 1'($urandom); halt = 1'($urandom);
         tgt = 16'($urandom); off = 16'($urandom);
         #1;
         chk("halt_halted", {15'd0, halted}, 16'd1);
         chk("halt_req", {15'd0, req}, 16'd0);
         chk("halt_pc", pc, m_pc);
         chk("halt_valid", {15'd0, valid}, 16'd0);
         chk("halt_redir", {15'd0, redirect}, 16'd0);
      end
   endtask

   initial begin
      do_reset();
      // Sequential fetches from reset
      run_instr(0, 0, 0, K_SEQ, 16'h0, 16'h0);
      run_instr(0, 1, 0, K_SEQ, 16'h0, 16'h0);
      run_instr(0, 0, 2, K_SEQ, 16'h0, 16'h0);
      // Backward branch from 0x0010
      run_instr(0, 0, 0, K_JMP, 16'h0, 16'h0010);
      run_instr(0, 0, 1, K_BR, 16'hFFFB, 16'h0);
      // Branch landing on pc+1 still redirects
      run_instr(0, 0, 0, K_BR, 16'h0000, 16'h0);
      // Wrap at 0xFFFF
      run_instr(0, 0, 0, K_JMP, 16'h0, 16'hFFFF);
      run_instr(0, 0, 0, K_SEQ, 16'h0, 16'h0);
      // Jump beats branch
      run_instr(0, 0, 0, K_JMP, 16'h0, 16'h0004);
      run_instr(0, 0, 0, K_JMPBR, 16'h0007, 16'h1234);
      // Stall with ack held high
      run_instr(3, 0, 0, K_SEQ, 16'h0, 16'h0);
      // Random instruction mix
      for (int n = 0; n < 60; n++) begin
         int k = int'($urandom_range(0, 3));
         run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), k, 16'($urandom), 16'($urandom));
      end
      // Halt at 0x0020
      run_instr(0, 0, 0, K_JMP, 16'h0, 16'h0020);
      run_instr(0, 0, 1, K_HALT, 16'h0, 16'h0);
      check_halted(5);
      // Leave HALTED via reset, then reset asynchronously mid-EXEC at 0x0042
      do_reset();
      run_instr(0, 0, 0, K_BR, 16'h0040, 16'h0);
      run_instr(0, 0, 0, K_JMP, 16'h0, 16'h0042);
      @(negedge clk);
      clear_inputs();
      ack = 1'b1;
      #1;
      chk("pre_rst_addr", addr, 16'h0042);
      @(negedge clk);
      clear_inputs();
      #1;
      chk("pre_rst_valid", {15'd0, valid}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b1;
      #1;
      chk("post_boot_req", {15'd0, req}, 16'd0);
      @(negedge clk);
      #1;
      chk("post_fetch_req", {15'd0, req}, 16'd1);
      chk("post_fetch_addr", addr, 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
